// File: rtl/counter_arbiter_pkg.sv
// Shared op encodings and FSM state type for the round-robin counter arbiter.
package counter_arbiter_pkg;

   localparam logic [1:0] OP_INC  = 2'b00;
   localparam logic [1:0] OP_DEC  = 2'b01;
   localparam logic [1:0] OP_LOAD = 2'b10;
   localparam logic [1:0] OP_READ = 2'b11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_EXEC = 1'b1
   } state_t;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr and wraps upward.
module rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   gnt_idx
);

   // first requester at or after ptr wins
   always_comb begin
      int  idx_v;
      logic found_v;
      gnt     = '0;
      gnt_idx = '0;
      found_v = 1'b0;
      idx_v   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx_v = (int'(ptr) + k) % NREQ;
         if (!found_v && req[idx_v]) begin
            found_v    = 1'b1;
            gnt[idx_v] = 1'b1;
            gnt_idx    = IW'(idx_v);
         end else begin
            found_v = found_v;
         end
      end
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner of a shared up/down counter; one op per two cycles.
// Define COUNTER_ARBITER_FORMAL_EN to compile in the embedded assertions and covers.
module counter_arbiter
   import counter_arbiter_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int NREQ  = 4,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_data,
   output logic [NREQ-1:0]       req_ready,
   output logic                  rsp_valid,
   output logic [IW-1:0]         rsp_id,
   output logic [WIDTH-1:0]      rsp_data,
   output logic                  rsp_wrap,
   output logic [WIDTH-1:0]      count
);

   state_t           state_q, state_d;
   logic [IW-1:0]    ptr_q, ptr_d, id_q, id_d, rsp_id_q, rsp_id_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] data_q, data_d, count_q, count_d, rsp_data_q, rsp_data_d;
   logic             rsp_valid_q, rsp_valid_d, rsp_wrap_q, rsp_wrap_d;
   logic [NREQ-1:0]  gnt_s;
   logic [IW-1:0]    gnt_idx_s;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req     (req_valid),
      .ptr     (ptr_q),
      .gnt     (gnt_s),
      .gnt_idx (gnt_idx_s)
   );

   assign req_ready = (state_q == ST_IDLE) ? gnt_s : '0;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_wrap  = rsp_wrap_q;
   assign count     = count_q;

   // next-state, counter update and response generation
   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      id_d        = id_q;
      op_d        = op_q;
      data_d      = data_q;
      count_d     = count_q;
      rsp_valid_d = 1'b0;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_wrap_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|req_valid) begin
               id_d    = gnt_idx_s;
               op_d    = req_op[2*gnt_idx_s +: 2];
               data_d  = req_data[WIDTH*gnt_idx_s +: WIDTH];
               state_d = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            case (op_q)
               OP_INC: begin
                  count_d    = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                  rsp_wrap_d = &count_q;
               end
               OP_DEC: begin
                  count_d    = count_q - {{(WIDTH-1){1'b0}}, 1'b1};
                  rsp_wrap_d = ~|count_q;
               end
               OP_LOAD: count_d = data_q;
               OP_READ: count_d = count_q;
               default: count_d = count_q;
            endcase
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_data_d  = count_d;
            ptr_d       = (id_q == IW'(NREQ-1)) ? {IW{1'b0}} : id_q + {{(IW-1){1'b0}}, 1'b1};
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // state, counter and response registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         id_q        <= '0;
         op_q        <= OP_INC;
         data_q      <= '0;
         count_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
         rsp_wrap_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         id_q        <= id_d;
         op_q        <= op_d;
         data_q      <= data_d;
         count_q     <= count_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
         rsp_wrap_q  <= rsp_wrap_d;
      end
   end

`ifdef COUNTER_ARBITER_FORMAL_EN
   logic           past_valid_q;
   logic [4:0]     wait_q [NREQ];
   logic           accept_s;

   assign accept_s = |(req_valid & req_ready);

   // enables $past-based properties after the first clock
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) past_valid_q <= 1'b0;
      else        past_valid_q <= 1'b1;
   end

   // grants seen by each pending requester while it waits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREQ; i++) wait_q[i] <= '0;
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || req_ready[i]) wait_q[i] <= '0;
            else if (accept_s)                 wait_q[i] <= wait_q[i] + 5'd1;
            else                               wait_q[i] <= wait_q[i];
         end
      end
   end

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
   a_ready_exec:   assert property (@(posedge clk) disable iff (!rst_n)
                      state_q == ST_EXEC |-> req_ready == '0);
   a_rsp_after:    assert property (@(posedge clk) disable iff (!rst_n)
                      past_valid_q && rsp_valid_q |-> $past(state_q) == ST_EXEC);
   a_count_chg:    assert property (@(posedge clk) disable iff (!rst_n)
                      past_valid_q && count_q != $past(count_q) |-> $past(state_q) == ST_EXEC);
   a_inc_delta:    assert property (@(posedge clk) disable iff (!rst_n)
                      past_valid_q && $past(state_q == ST_EXEC && op_q == OP_INC)
                      |-> count_q == $past(count_q) + {{(WIDTH-1){1'b0}}, 1'b1});
   a_dec_delta:    assert property (@(posedge clk) disable iff (!rst_n)
                      past_valid_q && $past(state_q == ST_EXEC && op_q == OP_DEC)
                      |-> count_q == $past(count_q) - {{(WIDTH-1){1'b0}}, 1'b1});

   for (genvar g = 0; g < NREQ; g++) begin : g_starve
      a_starve: assert property (@(posedge clk) disable iff (!rst_n) wait_q[g] < 5'(NREQ));
   end

   c_inc:      cover property (@(posedge clk) state_q == ST_EXEC && op_q == OP_INC);
   c_dec:      cover property (@(posedge clk) state_q == ST_EXEC && op_q == OP_DEC);
   c_load:     cover property (@(posedge clk) state_q == ST_EXEC && op_q == OP_LOAD);
   c_read:     cover property (@(posedge clk) state_q == ST_EXEC && op_q == OP_READ);
   c_wrap_up:  cover property (@(posedge clk) state_q == ST_EXEC && op_q == OP_INC && &count_q);
   c_wrap_dn:  cover property (@(posedge clk) state_q == ST_EXEC && op_q == OP_DEC && ~|count_q);
`endif

endmodule

// File: tb/tb_counter_arbiter.sv
// Scoreboard bench for counter_arbiter: a reference model predicts grants and responses.
module tb_counter_arbiter;

   localparam int W = 64;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req_valid = '0;
   logic [2*N-1:0] req_op = '0;
   logic [W*N-1:0] req_data = '0;
   logic [N-1:0]   req_ready;
   logic           rsp_valid;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_data;
   logic           rsp_wrap;
   logic [W-1:0]   count;

   counter_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
      .req_data(req_data), .req_ready(req_ready), .rsp_valid(rsp_valid),
      .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_wrap(rsp_wrap), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]   id;
      logic [W-1:0] data;
      logic         wrap;
      int           acc_cyc;
   } exp_t;

   exp_t         exp_q[$];
   int           n_chk = 0;
   int           n_pass = 0;
   int           cyc = 0;
   int           rem[N];
   logic [1:0]   r_op[N];
   logic [W-1:0] r_data[N];
   logic [W-1:0] m_cnt;
   int           m_ptr;
   bit           m_exec;
   int           grant_log[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // response monitor: every pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n) begin
         if (rsp_valid) begin
            if (exp_q.size() == 0) begin
               check_val("rsp_unexpected", 64'd1, 64'd0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check_val("rsp_id", W'(rsp_id), W'(e.id));
               check_val("rsp_data", rsp_data, e.data);
               check_val("rsp_wrap", W'(rsp_wrap), W'(e.wrap));
               check_val("count", count, e.data);
               check_val("rsp_latency", W'(cyc - e.acc_cyc), 64'd2);
            end
         end else if (rsp_wrap !== 1'b0) begin
            check_val("wrap_idle", W'(rsp_wrap), 64'd0);
         end
      end
   end

   task automatic apply_inputs();
      for (int i = 0; i < N; i++) begin
         req_valid[i]        = (rem[i] > 0);
         req_op[2*i +: 2]    = r_op[i];
         req_data[W*i +: W]  = r_data[i];
      end
   endtask

   task automatic step();
      logic [N-1:0] exp_rdy;
      int           w;
      exp_t         e;
      @(negedge clk);
      if (!m_exec) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         exp_rdy = '0;
         if (w >= 0) exp_rdy[w] = 1'b1;
         check_val("req_ready", W'(req_ready), W'(exp_rdy));
         if (w >= 0) begin
            e.id = 2'(w);
            e.acc_cyc = cyc;
            e.wrap = 1'b0;
            case (r_op[w])
               2'b00: begin e.wrap = (m_cnt == {W{1'b1}}); e.data = m_cnt + 64'd1; end
               2'b01: begin e.wrap = (m_cnt == 64'd0);     e.data = m_cnt - 64'd1; end
               2'b10: e.data = r_data[w];
               default: e.data = m_cnt;
            endcase
            exp_q.push_back(e);
            grant_log.push_back(w);
            m_cnt  = e.data;
            m_ptr  = (w + 1) % N;
            m_exec = 1'b1;
            rem[w]--;
         end
      end else begin
         check_val("ready_exec", W'(req_ready), 64'd0);
         m_exec = 1'b0;
      end
      @(posedge clk);
      #1;
      apply_inputs();
   endtask

   task automatic run_until_idle(input int bound);
      int n;
      bit busy;
      n = 0;
      busy = 1'b1;
      while (busy && n < bound) begin
         step();
         n++;
         busy = m_exec || (exp_q.size() > 0);
         for (int i = 0; i < N; i++) if (rem[i] > 0) busy = 1'b1;
      end
      if (busy) check_val("timeout", 64'd1, 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin rem[i] = 0; r_op[i] = 2'b00; r_data[i] = '0; end
      apply_inputs();
      exp_q.delete();
      grant_log.delete();
      m_cnt = '0; m_ptr = 0; m_exec = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int n, input logic [1:0] op, input logic [W-1:0] d);
      rem[i] = n; r_op[i] = op; r_data[i] = d;
   endtask

   initial begin
      do_reset();
      @(negedge clk);
      check_val("rst_rsp_valid", W'(rsp_valid), 64'd0);
      check_val("rst_rsp_id", W'(rsp_id), 64'd0);
      check_val("rst_rsp_data", rsp_data, 64'd0);
      check_val("rst_rsp_wrap", W'(rsp_wrap), 64'd0);
      check_val("rst_ready", W'(req_ready), 64'd0);
      check_val("rst_count", count, 64'd0);
      @(posedge clk); #1;

      // single LOAD from requester 2
      set_req(2, 1, 2'b10, 64'h0000_0000_AAAA_0000);
      apply_inputs();
      run_until_idle(20);

      // all four hold INC: order 0,1,2,3,0
      do_reset();
      set_req(0, 2, 2'b00, '0);
      for (int i = 1; i < N; i++) set_req(i, 1, 2'b00, '0);
      apply_inputs();
      run_until_idle(40);
      check_val("grant_cnt", W'(grant_log.size()), 64'd5);
      for (int i = 0; i < 5 && i < grant_log.size(); i++)
         check_val("grant_order", W'(grant_log[i]), W'(i % N));

      // wrap in both directions
      do_reset();
      set_req(2, 1, 2'b10, {W{1'b1}}); apply_inputs(); run_until_idle(20);
      set_req(2, 1, 2'b00, '0);        apply_inputs(); run_until_idle(20);
      set_req(2, 1, 2'b01, '0);        apply_inputs(); run_until_idle(20);

      // READ inside an INC stream
      do_reset();
      set_req(0, 3, 2'b00, '0);
      set_req(1, 1, 2'b11, '0);
      apply_inputs();
      run_until_idle(40);

      // requester 1 withdraws while 3 holds
      set_req(0, 1, 2'b11, '0); apply_inputs();
      step();
      set_req(1, 1, 2'b00, '0); set_req(3, 1, 2'b01, '0); apply_inputs();
      step();
      rem[1] = 0; apply_inputs();
      run_until_idle(20);

      // reset in the middle of EXEC
      do_reset();
      set_req(1, 1, 2'b10, 64'h1234_5678_9ABC_DEF0); apply_inputs();
      step();
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      m_cnt = '0; m_ptr = 0; m_exec = 1'b0; rem[1] = 0;
      check_val("mid_rst_count", count, 64'd0);
      @(negedge clk);
      check_val("mid_rst_rsp", W'(rsp_valid), 64'd0);
      rst_n = 1'b1;
      set_req(0, 1, 2'b00, '0); set_req(3, 1, 2'b00, '0);
      @(posedge clk); #1;
      apply_inputs();
      run_until_idle(30);

      // random mix
      for (int r = 0; r < 30; r++) begin
         for (int i = 0; i < N; i++)
            set_req(i, $urandom_range(0, 2), 2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom_range(0, 5)));
         apply_inputs();
         run_until_idle(60);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
